// File: rtl/number_entry_pkg.sv
// Shared key codes, radix constants and FSM state type for the number-entry engine.
package number_entry_pkg;

  localparam logic [4:0] KEY_CLEAR = 5'd16;
  localparam logic [4:0] KEY_BKSP  = 5'd17;
  localparam logic [4:0] KEY_LOAD  = 5'd18;
  localparam logic [4:0] KEY_NEG   = 5'd19;

  localparam logic [4:0] RADIX_DEC = 5'd10;
  localparam logic [4:0] RADIX_HEX = 5'd16;

  typedef enum logic {
    IDLE,
    DIV
  } state_e;

endpackage

// File: rtl/number_entry_gen_if.sv
// Key/operand bundle between the keypad decoder (master) and the number-entry engine (slave).
interface number_entry_gen_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DIGITS = 8
);
  localparam int unsigned CW = $clog2(DIGITS + 1);

  logic             key_valid;
  logic [4:0]       key_code;
  logic             hex_mode;
  logic [WIDTH-1:0] numRam;
  logic [WIDTH-1:0] num;
  logic [CW-1:0]    digit_cnt;
  logic             busy;
  logic             overflow;
  logic             key_drop;

  modport master (
    output key_valid, key_code, hex_mode, numRam,
    input  num, digit_cnt, busy, overflow, key_drop
  );

  modport slave (
    input  key_valid, key_code, hex_mode, numRam,
    output num, digit_cnt, busy, overflow, key_drop
  );

endinterface

// File: rtl/radix_div.sv
// Serial restoring divider by 10 or 16; WIDTH steps, first step taken on the start edge.
module radix_div
  import number_entry_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             hex,
  input  logic [WIDTH-1:0] dividend,
  output logic [WIDTH-1:0] quotient,
  output logic [4:0]       remainder,
  output logic             done
);
  localparam int unsigned NW = $clog2(WIDTH + 1);

  logic [4:0]       div_q, div_d, rem_q, rem_d;
  logic [4:0]       div_s, rem_s, rem_step;
  logic [WIDTH-1:0] quo_q, quo_d, quo_s, quo_step;
  logic [5:0]       trial;
  logic [NW-1:0]    left_q, left_d;
  logic             run_q, run_d, done_q, done_d;

  // Remainder stays below the divisor (<=16), so a 6-bit trial value is enough.
  always_comb begin
    div_s = start ? (hex ? RADIX_HEX : RADIX_DEC) : div_q;
    rem_s = start ? '0 : rem_q;
    quo_s = start ? dividend : quo_q;
    trial = {rem_s, quo_s[WIDTH-1]};
    if (trial >= {1'b0, div_s}) begin
      rem_step = 5'(trial - {1'b0, div_s});
      quo_step = {quo_s[WIDTH-2:0], 1'b1};
    end else begin
      rem_step = trial[4:0];
      quo_step = {quo_s[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    div_d  = div_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    left_d = left_q;
    run_d  = run_q;
    done_d = 1'b0;
    if (start) begin
      div_d  = div_s;
      rem_d  = rem_step;
      quo_d  = quo_step;
      left_d = NW'(WIDTH - 1);
      run_d  = 1'b1;
    end else if (run_q) begin
      rem_d  = rem_step;
      quo_d  = quo_step;
      left_d = left_q - NW'(1);
      if (left_q == NW'(1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= RADIX_DEC;
      rem_q  <= '0;
      quo_q  <= '0;
      left_q <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      left_q <= left_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign done      = done_q;

endmodule

// File: rtl/number_entry_gen.sv
// Keypad number-entry engine: digits, clear, backspace (serial divide), load, negate.
// Define NUMBER_ENTRY_NEG_EN for a signed operand with NEGATE support.
module number_entry_gen
  import number_entry_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DIGITS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  number_entry_gen_if.slave bus
);
  localparam int unsigned CW = $clog2(DIGITS + 1);
  localparam int unsigned XW = WIDTH + 4;
`ifdef NUMBER_ENTRY_NEG_EN
  localparam logic [XW-1:0] MAXMAG = {5'b0, {(WIDTH - 1){1'b1}}};
`else
  localparam logic [XW-1:0] MAXMAG = {4'b0, {WIDTH{1'b1}}};
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             loaded_q, loaded_d, hex_q, hex_d, ovf_q, ovf_d, drop_q, drop_d, rel_q;
  logic             busy, key_acc, bksp_go, div_start, div_done, done;
  logic [WIDTH-1:0] quotient;
  logic [4:0]       rem_unused;
  logic             is_digit, eff_hex, ignore, reject;
  logic [3:0]       digit;
  logic [XW-1:0]    base_x, prod, cand;
  logic [CW-1:0]    cnt_base;
`ifdef NUMBER_ENTRY_NEG_EN
  logic             sign_q, sign_d;
`endif

  assign key_acc = bus.key_valid && !busy;
  assign bksp_go = key_acc && (bus.key_code == KEY_BKSP) && (cnt_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bksp_go) state_d = DIV;
      DIV:     if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == DIV);
    div_start = (state_q == IDLE) && bksp_go;
    div_done  = (state_q == DIV) && done;
  end

  // A loaded value is replaced, not extended, by the next digit.
  always_comb begin
    is_digit = ~bus.key_code[4];
    digit    = bus.key_code[3:0];
    eff_hex  = (cnt_q == '0) ? bus.hex_mode : hex_q;
    ignore   = !eff_hex && (digit > 4'd9);
    base_x   = loaded_q ? '0 : {4'b0, mag_q};
    cnt_base = loaded_q ? '0 : cnt_q;
    prod     = eff_hex ? (base_x << 4) : (base_x << 3) + (base_x << 1);
    cand     = prod + XW'(digit);
    reject   = (cnt_base == CW'(DIGITS)) || (cand > MAXMAG);
  end

  always_comb begin
    mag_d    = mag_q;
    cnt_d    = cnt_q;
    loaded_d = loaded_q;
    hex_d    = rel_q ? hex_q : bus.hex_mode;
    ovf_d    = ovf_q;
    drop_d   = bus.key_valid && busy;
`ifdef NUMBER_ENTRY_NEG_EN
    sign_d   = sign_q;
`endif
    if (key_acc) begin
      if (is_digit) begin
        if (cnt_q == '0) hex_d = bus.hex_mode;
        if (!ignore) begin
          if (reject) begin
            ovf_d = 1'b1;
          end else begin
            mag_d    = cand[WIDTH-1:0];
            cnt_d    = cnt_base + CW'(1);
            loaded_d = 1'b0;
`ifdef NUMBER_ENTRY_NEG_EN
            if (loaded_q) sign_d = 1'b0;
`endif
          end
        end
      end else begin
        case (bus.key_code)
          KEY_CLEAR: begin
            mag_d    = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
            loaded_d = 1'b0;
            hex_d    = bus.hex_mode;
`ifdef NUMBER_ENTRY_NEG_EN
            sign_d   = 1'b0;
`endif
          end
          KEY_LOAD: begin
`ifdef NUMBER_ENTRY_NEG_EN
            sign_d   = bus.numRam[WIDTH-1];
            mag_d    = bus.numRam[WIDTH-1] ? -bus.numRam : bus.numRam;
`else
            mag_d    = bus.numRam;
`endif
            cnt_d    = '0;
            ovf_d    = 1'b0;
            loaded_d = 1'b1;
            hex_d    = bus.hex_mode;
          end
          KEY_NEG: begin
`ifdef NUMBER_ENTRY_NEG_EN
            if (mag_q != '0) sign_d = !sign_q;
`endif
          end
          default: ;
        endcase
      end
    end
    if (div_done) begin
      mag_d = quotient;
      cnt_d = cnt_q - CW'(1);
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_q    <= '0;
      cnt_q    <= '0;
      loaded_q <= 1'b0;
      hex_q    <= 1'b0;
      ovf_q    <= 1'b0;
      drop_q   <= 1'b0;
      rel_q    <= 1'b0;
    end else begin
      mag_q    <= mag_d;
      cnt_q    <= cnt_d;
      loaded_q <= loaded_d;
      hex_q    <= hex_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
      rel_q    <= 1'b1;
    end
  end

`ifdef NUMBER_ENTRY_NEG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sign_q <= 1'b0;
    else        sign_q <= sign_d;
  end

  assign bus.num = sign_q ? -mag_q : mag_q;
`else
  assign bus.num = mag_q;
`endif

  assign bus.digit_cnt = cnt_q;
  assign bus.busy      = busy;
  assign bus.overflow  = ovf_q;
  assign bus.key_drop  = drop_q;

  radix_div #(
    .WIDTH (WIDTH)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .hex       (hex_q),
    .dividend  (mag_q),
    .quotient  (quotient),
    .remainder (rem_unused),
    .done      (done)
  );

endmodule
